// File: rtl/tag_array_nway_if.sv
// Bus bundle for tag_array_nway.
// master: cache controller side (drives lookup/fill/flush requests).
// slave : tag array side (returns hit, victim and flush status).
//   index/lookup_tag          -> set and tag for the combinational lookup
//   hit/hit_way               <- lookup result (hit forced 0 while busy)
//   victim_way/valid/dirty/tag<- replacement candidate of the indexed set
//   access_en/dirty_en        -> on a hit: make hit_way MRU / mark it dirty
//   fill_en/way/tag/dirty     -> install a tag into a way of the indexed set
//   flush_req/busy/flush_done -> invalidate-all handshake
interface tag_array_nway_if #(
    parameter int WAYS    = 2,
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 22
);
    localparam int WAY_W = $clog2(WAYS);

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   lookup_tag;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   victim_way;
    logic               victim_valid;
    logic               victim_dirty;
    logic [TAG_W-1:0]   victim_tag;
    logic               access_en;
    logic               dirty_en;
    logic               fill_en;
    logic [WAY_W-1:0]   fill_way;
    logic [TAG_W-1:0]   fill_tag;
    logic               fill_dirty;
    logic               flush_req;
    logic               busy;
    logic               flush_done;

    modport master (
        output index, lookup_tag, access_en, dirty_en, fill_en, fill_way,
               fill_tag, fill_dirty, flush_req,
        input  hit, hit_way, victim_way, victim_valid, victim_dirty,
               victim_tag, busy, flush_done
    );

    modport slave (
        input  index, lookup_tag, access_en, dirty_en, fill_en, fill_way,
               fill_tag, fill_dirty, flush_req,
        output hit, hit_way, victim_way, victim_valid, victim_dirty,
               victim_tag, busy, flush_done
    );
endinterface

// File: rtl/tag_array_nway.sv
// Set-associative tag store with per-set tree pseudo-LRU and a
// one-set-per-cycle flush engine.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - tag_array_nway_if.slave (lookup, victim, fill, flush signals)
// Lookup and victim selection are combinational from the current array
// state; fills, dirty marking and PLRU updates land on the next edge.
module tag_array_nway #(
    parameter int WAYS    = 2,
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 22
) (
    input  logic             clk,
    input  logic             rst,
    tag_array_nway_if.slave  bus
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_e;

    state_e             state_q, state_d;
    logic [INDEX_W-1:0] cnt_q, cnt_d;

    logic [WAYS-1:0][TAG_W-1:0] tag_q   [SETS];
    logic [WAYS-1:0][TAG_W-1:0] tag_d   [SETS];
    logic [WAYS-1:0]            valid_q [SETS];
    logic [WAYS-1:0]            valid_d [SETS];
    logic [WAYS-1:0]            dirty_q [SETS];
    logic [WAYS-1:0]            dirty_d [SETS];
    // Three tree bits per set; for 2 ways only bit 0 is ever written.
    logic [2:0]                 plru_q  [SETS];
    logic [2:0]                 plru_d  [SETS];

    logic             busy;
    logic [WAYS-1:0]  match;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim_way;

    // Point the tree away from the way just used.
    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
        logic [2:0] r;
        r = p;
        if (WAYS == 2) begin
            r[0] = ~w[0];
        end else if (!w[1]) begin
            r[0] = 1'b1;
            r[1] = ~w[0];
        end else begin
            r[0] = 1'b0;
            r[2] = ~w[0];
        end
        return r;
    endfunction

    function automatic logic [1:0] plru_victim(input logic [2:0] p);
        if (WAYS == 2) return {1'b0, p[0]};
        return p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
    endfunction

    assign busy = (state_q == FLUSH);

    // Read path
    always_comb begin
        match      = '0;
        hit_way    = '0;
        victim_way = WAY_W'(plru_victim(plru_q[bus.index]));
        for (int w = 0; w < WAYS; w++)
            match[w] = valid_q[bus.index][w] && (tag_q[bus.index][w] == bus.lookup_tag);
        hit = (|match) && !busy;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w] && !busy) hit_way = WAY_W'(w);
            if (!valid_q[bus.index][w]) victim_way = WAY_W'(w);
        end
    end

    assign bus.hit          = hit;
    assign bus.hit_way      = hit_way;
    assign bus.victim_way   = victim_way;
    assign bus.victim_valid = valid_q[bus.index][victim_way];
    assign bus.victim_dirty = dirty_q[bus.index][victim_way];
    assign bus.victim_tag   = tag_q[bus.index][victim_way];
    assign bus.busy         = busy;
    assign bus.flush_done   = (state_q == DONE);

    // Next state: flush engine first; request-side writes only when not busy
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        plru_d  = plru_q;

        case (state_q)
            IDLE: begin
                if (bus.flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                valid_d[cnt_q] = '0;
                dirty_d[cnt_q] = '0;
                plru_d[cnt_q]  = '0;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == INDEX_W'(SETS - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (!busy) begin
            if (bus.fill_en) begin
                tag_d[bus.index][bus.fill_way]   = bus.fill_tag;
                valid_d[bus.index][bus.fill_way] = 1'b1;
                dirty_d[bus.index][bus.fill_way] = bus.fill_dirty;
                plru_d[bus.index] = plru_touch(plru_q[bus.index], 2'(bus.fill_way));
            end else if (hit) begin
                if (bus.access_en)
                    plru_d[bus.index] = plru_touch(plru_q[bus.index], 2'(hit_way));
                if (bus.dirty_en)
                    dirty_d[bus.index][hit_way] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                tag_q[s]   <= '0;
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            plru_q  <= plru_d;
        end
    end
endmodule
